// File: rtl/ci_deinterleaver_aligned.sv
// ci_deinterleaver_aligned
//   Receive-side convolutional deinterleaver for the CI path. Lane i (of P)
//   delays its symbols by i*D lane accesses, undoing the (P-1-i)*D delays of
//   the transmit interleaver. The commutator locks to a start-of-frame marker.
//   Output symbols whose lane buffer has not yet been filled since reset/relock
//   are tagged with out_fill.
//
// Handshake: a transfer happens on a rising clk edge when valid & ready are
//   both high. The producer holds data/valid stable until the transfer; the
//   consumer may change ready freely. in_ready = !out_valid | out_ready, so an
//   input is only taken when the single output register is free or draining
//   in the same cycle.
//
// Ports
//   clk, rstn           clock, asynchronous active-low reset
//   sym_in[M*W]         CI symbol in
//   in_valid/in_ready   input handshake
//   in_sof              sym_in is commutator lane 0 (frame start)
//   sym_out[M*W]        deinterleaved CI symbol
//   out_valid/out_ready output handshake
//   out_fill            sym_out is reset-fill content, not received data
//   locked              commutator aligned (FSM in LOCK)
//   align_err           one-cycle pulse: sof received while not on lane 0
module ci_deinterleaver_aligned #(
  parameter int M = 10,
  parameter int W = 1,
  parameter int D = 2,
  parameter int P = 4
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [M*W-1:0] sym_in,
  input  logic           in_valid,
  input  logic           in_sof,
  output logic           in_ready,
  output logic [M*W-1:0] sym_out,
  output logic           out_valid,
  output logic           out_fill,
  input  logic           out_ready,
  output logic           locked,
  output logic           align_err
);

  localparam int SW  = M * W;
  localparam int TOT = D * P * (P - 1) / 2;            // all lane buffers
  localparam int AW  = (TOT > 1) ? $clog2(TOT) : 1;
  localparam int CW  = $clog2((P - 1) * D + 1);        // ptr / fill counter
  localparam int LW  = $clog2(P);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t          state;
  logic [LW-1:0]   idx;
  logic [CW-1:0]   ptr [P];
  logic [CW-1:0]   fc  [P];
  logic [SW-1:0]   mem [TOT];

  logic            acc;
  logic            take;
  logic            relock;
  logic            delayed;
  logic [LW-1:0]   lane;
  logic [CW-1:0]   depth;
  logic [AW-1:0]   rd_addr;
  logic [SW-1:0]   rd_data;

  // Buffer depth of lane l.
  function automatic logic [CW-1:0] lane_depth(input logic [LW-1:0] l);
    return CW'(int'(l) * D);
  endfunction

  // Start of lane l inside the shared memory: lanes 1..l-1 packed before it.
  function automatic logic [AW-1:0] lane_base(input logic [LW-1:0] l);
    int li;
    li = int'(l);
    return AW'(D * li * (li - 1) / 2);
  endfunction

  assign in_ready = !out_valid | out_ready;
  assign acc      = in_valid & in_ready;

  always_comb begin
    // A sof always forces lane 0; in HUNT only sof symbols are processed.
    lane    = in_sof ? '0 : idx;
    take    = acc & ((state == LOCK) | in_sof);
    // Any sof that is not an in-order lane-0 arrival restarts the lanes.
    relock  = acc & in_sof & ((state == HUNT) | (idx != '0));
    delayed = (lane != '0);
    depth   = lane_depth(lane);
    rd_addr = lane_base(lane) + AW'(ptr[lane]);
    rd_data = mem[rd_addr];
  end

  // Delay RAM: not reset, stale content is covered by the fill counters.
  always_ff @(posedge clk) begin
    if (take && delayed) mem[rd_addr] <= sym_in;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= HUNT;
      idx       <= '0;
      sym_out   <= '0;
      out_valid <= 1'b0;
      out_fill  <= 1'b0;
      locked    <= 1'b0;
      align_err <= 1'b0;
      for (int i = 0; i < P; i++) begin
        ptr[i] <= '0;
        fc[i]  <= '0;
      end
    end else begin
      align_err <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (take) begin
        state     <= LOCK;
        locked    <= 1'b1;
        out_valid <= 1'b1;
        idx       <= (lane == LW'(P - 1)) ? '0 : lane + LW'(1);

        if (relock) begin
          if (state == LOCK) align_err <= 1'b1;
          for (int i = 0; i < P; i++) begin
            ptr[i] <= '0;
            fc[i]  <= '0;
          end
        end

        if (!delayed) begin
          sym_out  <= sym_in;
          out_fill <= 1'b0;
        end else begin
          // Read-before-write at the lane pointer, then advance/wrap.
          sym_out     <= rd_data;
          out_fill    <= (fc[lane] < depth);
          ptr[lane]   <= (ptr[lane] == depth - CW'(1)) ? '0 : ptr[lane] + CW'(1);
          if (fc[lane] < depth) fc[lane] <= fc[lane] + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ci_deinterleaver_aligned.sv
module tb_ci_deinterleaver_aligned;

  localparam int M  = 10;
  localparam int W  = 1;
  localparam int D  = 2;
  localparam int P  = 4;
  localparam int SW = M * W;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [SW-1:0] sym_in = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic [SW-1:0] sym_out;
  logic          out_valid;
  logic          out_fill;
  logic          out_ready = 1'b1;
  logic          locked;
  logic          align_err;

  int tests = 0;
  int fails = 0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] x [200];

  ci_deinterleaver_aligned #(.M(M), .W(W), .D(D), .P(P)) dut (
    .clk(clk), .rstn(rstn), .sym_in(sym_in), .in_valid(in_valid),
    .in_sof(in_sof), .in_ready(in_ready), .sym_out(sym_out),
    .out_valid(out_valid), .out_fill(out_fill), .out_ready(out_ready),
    .locked(locked), .align_err(align_err)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Output n of a clean stream whose input n carries value n.
  function automatic logic exp_fill(input int n);
    int i, k;
    i = n % P;
    k = n / P;
    return (k < i * D);
  endfunction

  function automatic logic [SW-1:0] exp_val(input int n);
    int i, k;
    i = n % P;
    k = n / P;
    return SW'(P * (k - i * D) + i);
  endfunction

  // ---------------- drivers ----------------
  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Present symbol n (value n), clock it in, check the produced output.
  task automatic drive_check(input int n, input logic sof);
    sym_in   = SW'(n);
    in_sof   = sof;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_sof = 1'b0;
    chk($sformatf("valid[%0d]", n), out_valid, 1'b1);
    chk($sformatf("fill[%0d]", n), out_fill, exp_fill(n));
    if (!exp_fill(n)) chk($sformatf("data[%0d]", n), sym_out, exp_val(n));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int n = 0; n < 200; n++) x[n] = SW'(n + 1);

    // Reset state
    do_reset();
    chk("rst_sym_out", sym_out, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_fill", out_fill, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_align_err", align_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);

    // 1: back-to-back 0..63 with sof on the first symbol
    drive_check(0, 1'b1);
    chk("t1_locked", locked, 1'b1);
    chk("t1_no_align_err", align_err, 1'b0);
    for (int n = 1; n < 64; n++) drive_check(n, 1'b0);
    in_valid = 1'b0;

    // 2: bench interleaver -> DUT, end-to-end delay P(P-1)D = 24
    do_reset();
    for (int n = 0; n < 200; n++) begin
      int j, src;
      j   = n % P;
      src = n - (P - 1 - j) * D * P;
      sym_in   = (src >= 0) ? x[src] : '0;
      in_sof   = (n == 0);
      in_valid = 1'b1;
      exp_q.push_back(x[n]);
      @(posedge clk);
      #1;
      in_sof = 1'b0;
      chk($sformatf("t2_valid[%0d]", n), out_valid, 1'b1);
      if (n >= P * (P - 1) * D) begin
        chk($sformatf("t2_fill[%0d]", n), out_fill, 1'b0);
        chk($sformatf("t2_data[%0d]", n), sym_out, exp_q.pop_front());
      end
    end
    in_valid = 1'b0;
    exp_q.delete();

    // 3: out_ready low for 5 cycles mid-stream
    do_reset();
    drive_check(0, 1'b1);
    for (int n = 1; n < 28; n++) drive_check(n, 1'b0);
    sym_in    = SW'(28);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk("t3_in_ready", in_ready, 1'b0);
      chk("t3_valid_hold", out_valid, 1'b1);
      chk("t3_data_hold", sym_out, SW'(3));
      chk("t3_fill_hold", out_fill, 1'b0);
    end
    out_ready = 1'b1;
    #1 chk("t3_in_ready_release", in_ready, 1'b1);
    for (int n = 28; n < 40; n++) drive_check(n, 1'b0);
    in_valid = 1'b0;

    // 4: 10 symbols without sof are dropped, then sof
    do_reset();
    for (int n = 0; n < 10; n++) begin
      sym_in   = SW'(500 + n);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t4_no_valid[%0d]", n), out_valid, 1'b0);
      chk($sformatf("t4_unlocked[%0d]", n), locked, 1'b0);
    end
    sym_in = SW'(10'h2AA);
    in_sof = 1'b1;
    @(posedge clk);
    #1;
    in_sof = 1'b0;
    chk("t4_first_valid", out_valid, 1'b1);
    chk("t4_first_fill", out_fill, 1'b0);
    chk("t4_first_data", sym_out, SW'(10'h2AA));
    chk("t4_locked", locked, 1'b1);
    chk("t4_no_align_err", align_err, 1'b0);

    // 5: one lane-1 symbol (idx -> 2), then sof at idx 2
    sym_in = SW'(10'h155);
    @(posedge clk);
    #1;
    chk("t5_lane1_fill", out_fill, 1'b1);
    chk("t5_pre_align_err", align_err, 1'b0);
    drive_check(0, 1'b1);
    chk("t5_align_err", align_err, 1'b1);
    chk("t5_locked", locked, 1'b1);
    drive_check(1, 1'b0);
    chk("t5_align_err_pulse", align_err, 1'b0);
    for (int n = 2; n < 32; n++) drive_check(n, 1'b0);
    in_valid = 1'b0;

    // 6: asynchronous reset pulse mid-stream
    #2 rstn = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_sym", sym_out, '0);
    chk("t6_async_fill", out_fill, 1'b0);
    chk("t6_async_locked", locked, 1'b0);
    #3 rstn = 1'b1;
    for (int n = 0; n < 3; n++) begin
      sym_in   = SW'(600 + n);
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("t6_hunt_valid[%0d]", n), out_valid, 1'b0);
      chk($sformatf("t6_hunt_locked[%0d]", n), locked, 1'b0);
    end
    sym_in = SW'(7);
    in_sof = 1'b1;
    @(posedge clk);
    #1;
    in_sof   = 1'b0;
    in_valid = 1'b0;
    chk("t6_sof_valid", out_valid, 1'b1);
    chk("t6_sof_fill", out_fill, 1'b0);
    chk("t6_sof_data", sym_out, SW'(7));
    chk("t6_sof_locked", locked, 1'b1);
    @(posedge clk);
    #1 chk("t6_drain", out_valid, 1'b0);

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
